// File: rtl/adder_tree_csa_feeder.sv
// Serial-to-parallel front end for the CSA adder tree: packs a frame of words,
// waits out the tree latency, and returns the captured sum on valid/ready.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   i_valid/o_ready    operand word handshake, i_data = operand word
//   i_flush            close a partial frame, unfilled slots read zero
//   o_tree_data        packed vector to the tree, slot 0 = first word
//   i_tree_sum         tree result, sampled TREE_LAT edges after frame close
//   o_valid/i_ready    result handshake, o_sum = captured frame sum
//   o_count            words accepted in the current frame
module adder_tree_csa_feeder #(
  parameter int I_DATA_W = 3,
  parameter int I_DATA_N = 32,
  parameter int O_DATA_W = 12,
  parameter int TREE_LAT = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic [I_DATA_W-1:0]                  i_data,
  input  logic                                 i_flush,
  output logic [0:I_DATA_N-1][I_DATA_W-1:0]    o_tree_data,
  input  logic [O_DATA_W-1:0]                  i_tree_sum,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [O_DATA_W-1:0]                  o_sum,
  output logic [$clog2(I_DATA_N+1)-1:0]        o_count
);

  localparam int CW = $clog2(I_DATA_N + 1);
  localparam int IW = (I_DATA_N > 1) ? $clog2(I_DATA_N) : 1;
  localparam int WW = (TREE_LAT > 1) ? $clog2(TREE_LAT) : 1;

  typedef enum logic [1:0] {
    S_FILL,
    S_WAIT,
    S_OUT
  } state_t;

  state_t        state;
  state_t        state_d;
  logic          accept;
  logic          full;
  logic          close;
  logic [CW-1:0] cnt_acc;
  logic [WW-1:0] wcnt;
  logic [IW-1:0] slot;

  assign o_ready = (state == S_FILL);
  assign o_valid = (state == S_OUT);
  assign slot    = o_count[IW-1:0];

  // cnt_acc already includes a word accepted this cycle, so a flush
  // arriving with the first word still closes a one-word frame.
  always_comb begin
    accept  = i_valid & o_ready;
    cnt_acc = o_count + CW'(accept);
    full    = accept && (o_count == CW'(I_DATA_N - 1));
    close   = o_ready && (full || (i_flush && (cnt_acc != '0)));
    state_d = state;
    unique case (state)
      S_FILL:  if (close) state_d = S_WAIT;
      S_WAIT:  if (wcnt == '0) state_d = S_OUT;
      S_OUT:   if (i_ready) state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FILL;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_tree_data <= '0;
      o_sum       <= '0;
      o_count     <= '0;
      wcnt        <= '0;
    end else begin
      unique case (state)
        S_FILL: begin
          if (accept) begin
            o_tree_data[slot] <= i_data;
            o_count           <= cnt_acc;
          end
          // Slots past the last accepted word are cleared so stale
          // words from an earlier frame never reach the tree.
          if (close) begin
            wcnt <= WW'(TREE_LAT - 1);
            for (int j = 0; j < I_DATA_N; j++) begin
              if (CW'(j) >= cnt_acc) begin
                o_tree_data[j] <= '0;
              end
            end
          end
        end
        S_WAIT: begin
          if (wcnt == '0) begin
            o_sum <= i_tree_sum;
          end else begin
            wcnt <= wcnt - WW'(1);
          end
        end
        S_OUT: begin
          if (i_ready) begin
            o_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_tree_csa_feeder.sv
// Self-checking bench for adder_tree_csa_feeder with a delay-line tree model.
// Frame sums and slot images come from a word-list reference model.
module tb_adder_tree_csa_feeder;

  localparam int W   = 3;
  localparam int N   = 32;
  localparam int OW  = 12;
  localparam int LAT = 8;
  localparam int CW  = $clog2(N + 1);

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    i_valid;
  logic                    o_ready;
  logic [W-1:0]            i_data;
  logic                    i_flush;
  logic [0:N-1][W-1:0]     o_tree_data;
  logic [OW-1:0]           i_tree_sum;
  logic                    o_valid;
  logic                    i_ready;
  logic [OW-1:0]           o_sum;
  logic [CW-1:0]           o_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adder_tree_csa_feeder #(
    .I_DATA_W(W), .I_DATA_N(N), .O_DATA_W(OW), .TREE_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_flush(i_flush), .o_tree_data(o_tree_data),
    .i_tree_sum(i_tree_sum), .o_valid(o_valid), .i_ready(i_ready),
    .o_sum(o_sum), .o_count(o_count)
  );

  // Tree model: the sum of the vector is valid LAT-1 edges after it
  // changes, so the feeder's sample at edge LAT sees the new frame.
  logic [OW-1:0] pipe [0:LAT-2];

  function automatic logic [OW-1:0] vsum(input logic [0:N-1][W-1:0] v);
    logic [OW-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + OW'(v[i]);
    return s;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= vsum(o_tree_data);
    for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
  end

  assign i_tree_sum = pipe[LAT-2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [W-1:0] d, input logic fl);
    int n;
    n = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_flush = fl;
    while (!o_ready) begin
      tick();
      n++;
      if (n > 200) begin
        $display("FAIL push_timeout o_ready=0 required 1");
        $fatal(1);
      end
    end
    tick();
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!o_valid) begin
      tick();
      n++;
      if (n > 100) begin
        $display("FAIL result_timeout o_valid=0 required 1");
        $fatal(1);
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_ready got %b want 1", o_ready);
    end
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_valid got %b want 0", o_valid);
    end
    n_cmp++;
    if (o_count !== '0) begin
      n_bad++; $display("FAIL rst_count got %0d want 0", o_count);
    end
    n_cmp++;
    if (o_sum !== '0) begin
      n_bad++; $display("FAIL rst_sum got %0d want 0", o_sum);
    end
    n_cmp++;
    if (o_tree_data !== '0) begin
      n_bad++; $display("FAIL rst_tree got %h want 0", o_tree_data);
    end
  endtask

  task automatic test_all_sevens();
    int n;
    for (int k = 0; k < N; k++) push(3'd7, 1'b0);
    n_cmp++;
    if (o_ready !== 1'b0 || o_count !== CW'(N)) begin
      n_bad++;
      $display("FAIL sev_wait ready=%b count=%0d want 0/%0d",
               o_ready, o_count, N);
    end
    wait_res(n);
    n_cmp++;
    if (n != LAT) begin
      n_bad++; $display("FAIL sev_latency got %0d want %0d edges", n, LAT);
    end
    n_cmp++;
    if (o_sum !== OW'(224) || o_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL sev_sum got %0d ready=%b want 224 ready=0",
               o_sum, o_ready);
    end
    tick();
    n_cmp++;
    if (o_valid !== 1'b0 || o_count !== '0 || o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL sev_release valid=%b count=%0d ready=%b want 0/0/1",
               o_valid, o_count, o_ready);
    end
  endtask

  task automatic test_gaps();
    int n;
    for (int k = 0; k < N; k++) begin
      push(W'(k % 8), 1'b0);
      n_cmp++;
      if (o_count !== CW'(k + 1)) begin
        n_bad++;
        $display("FAIL gap_step got %0d want %0d", o_count, k + 1);
      end
      tick();
      n_cmp++;
      if (o_count !== CW'(k + 1)) begin
        n_bad++;
        $display("FAIL gap_idle got %0d want %0d", o_count, k + 1);
      end
    end
    wait_res(n);
    n_cmp++;
    if (o_sum !== OW'(112)) begin
      n_bad++; $display("FAIL gap_sum got %0d want 112", o_sum);
    end
    tick();
  endtask

  task automatic test_out_stall();
    int n;
    i_ready = 1'b0;
    for (int k = 0; k < N; k++) push(3'd1, 1'b0);
    wait_res(n);
    i_valid = 1'b1;
    i_data  = 3'd5;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (o_valid !== 1'b1 || o_sum !== OW'(32) || o_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold valid=%b sum=%0d ready=%b want 1/32/0",
                 o_valid, o_sum, o_ready);
      end
      tick();
    end
    i_ready = 1'b1;
    tick();
    n_cmp++;
    if (o_count !== '0 || o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_back count=%0d ready=%b valid=%b want 0/1/0",
               o_count, o_ready, o_valid);
    end
    tick();
    i_valid = 1'b0;
    n_cmp++;
    if (o_count !== CW'(1) || o_tree_data[0] !== 3'd5) begin
      n_bad++;
      $display("FAIL stall_word count=%0d slot0=%0d want 1/5",
               o_count, o_tree_data[0]);
    end
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    wait_res(n);
    n_cmp++;
    if (o_sum !== OW'(5)) begin
      n_bad++; $display("FAIL stall_flush_sum got %0d want 5", o_sum);
    end
    tick();
  endtask

  task automatic test_flush();
    int n;
    logic [0:N-1][W-1:0] ev;
    push(3'd1, 1'b0);
    push(3'd2, 1'b0);
    push(3'd3, 1'b0);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    ev = '0;
    ev[0] = 3'd1;
    ev[1] = 3'd2;
    ev[2] = 3'd3;
    n_cmp++;
    if (o_tree_data !== ev || o_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fl_slots got %h ready=%b want %h ready=0",
               o_tree_data, o_ready, ev);
    end
    wait_res(n);
    n_cmp++;
    if (o_sum !== OW'(6)) begin
      n_bad++; $display("FAIL fl_sum got %0d want 6", o_sum);
    end
    tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    n_cmp++;
    if (o_ready !== 1'b1 || o_count !== '0) begin
      n_bad++;
      $display("FAIL fl_empty ready=%b count=%0d want 1/0",
               o_ready, o_count);
    end
    for (int k = 0; k < N; k++) push(3'd2, 1'b0);
    wait_res(n);
    n_cmp++;
    if (o_sum !== OW'(64)) begin
      n_bad++; $display("FAIL fl_twos got %0d want 64", o_sum);
    end
    tick();
    for (int k = 0; k < 3; k++) push(3'd4, 1'b0);
    push(3'd4, 1'b1);
    n_cmp++;
    if (o_count !== CW'(4) || o_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fl_coinc count=%0d ready=%b want 4/0",
               o_count, o_ready);
    end
    wait_res(n);
    n_cmp++;
    if (o_sum !== OW'(16)) begin
      n_bad++; $display("FAIL fl_coinc_sum got %0d want 16", o_sum);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int  n;
    logic seen;
    for (int k = 0; k < 10; k++) push(3'd3, 1'b0);
    do_reset();
    n_cmp++;
    if (o_count !== '0 || o_ready !== 1'b1 || o_tree_data !== '0) begin
      n_bad++;
      $display("FAIL mid_rst count=%0d ready=%b tree=%h want 0/1/0",
               o_count, o_ready, o_tree_data);
    end
    for (int k = 0; k < N; k++) push(3'd1, 1'b0);
    wait_res(n);
    n_cmp++;
    if (o_sum !== OW'(32)) begin
      n_bad++; $display("FAIL mid_sum got %0d want 32", o_sum);
    end
    tick();
    for (int k = 0; k < N; k++) push(3'd6, 1'b0);
    tick();
    tick();
    tick();
    do_reset();
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (o_valid) seen = 1'b1;
      tick();
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL wait_rst valid seen=%b want 0", seen);
    end
  endtask

  task automatic test_random();
    int n;
    int len;
    int exp;
    logic fl;
    logic [W-1:0] d;
    logic [0:N-1][W-1:0] ev;
    for (int f = 0; f < 8; f++) begin
      len = (f == 0) ? N : int'($urandom_range(1, N));
      exp = 0;
      ev  = '0;
      fl  = 1'b0;
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 2) == 0) tick();
        d = W'($urandom);
        ev[k] = d;
        exp += int'(d);
        fl = (k == len - 1) && (len < N) && ($urandom_range(0, 1) == 1);
        push(d, fl);
      end
      if (len < N && !fl) begin
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
      end
      wait_res(n);
      n_cmp++;
      if (o_sum !== OW'(exp) || o_tree_data !== ev) begin
        n_bad++;
        $display("FAIL rnd_frame%0d len=%0d sum=%0d want %0d tree=%h want %h",
                 f, len, o_sum, exp, o_tree_data, ev);
      end
      i_ready = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      i_ready = 1'b1;
      tick();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_flush = 1'b0;
    i_ready = 1'b1;
    do_reset();
    test_reset();
    test_all_sevens();
    test_gaps();
    test_out_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
